// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and status bundle for the PS/2 host transmitter.
// The master drives a command byte in; the slave reports progress and outcome.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_ok, error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_ok, error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// device-clocked shift of one byte with odd parity, then ACK sampling.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int REQ_CYCLES     = 25,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic            clk,
    input  logic            clr,
    ps2_host_tx_if.slave    bus,
    input  logic            ps2_clk_in,
    input  logic            ps2_data_in,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe
);
    localparam int CNT_W = 19;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [10:0]      shift;
    logic             ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic             ps2_data_p0, ps2_data_p1;
    logic             fall;
    logic             timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Stage boundary: two-flop synchronizers plus one history flop for edge detect
    always_ff @(posedge clk) begin
        ps2_clk_p0  <= ps2_clk_in;
        ps2_clk_p1  <= ps2_clk_p0;
        ps2_clk_p2  <= ps2_clk_p1;
        ps2_data_p0 <= ps2_data_in;
        ps2_data_p1 <= ps2_data_p0;
    end

    assign fall    = ps2_clk_p2 & ~ps2_clk_p1;
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign bus.tx_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            bus.done    <= 1'b0;
            bus.error   <= 1'b0;
            bus.ack_ok  <= 1'b0;
        end else begin
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        shift      <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        bus.ack_ok <= 1'b0;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        cnt         <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                REQ: begin
                    if (cnt == CNT_W'(REQ_CYCLES - 1)) begin
                        cnt        <= '0;
                        bit_idx    <= '0;
                        ps2_clk_oe <= 1'b0;
                        state      <= SEND;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                SEND: begin
                    if (fall) begin
                        cnt <= '0;
                        if (bit_idx == 4'd10) begin
                            // Eleventh falling edge: the device's ACK is on the data line now
                            bus.ack_ok  <= ~ps2_data_p1;
                            ps2_data_oe <= 1'b0;
                            state       <= WAIT_IDLE;
                        end else begin
                            ps2_data_oe <= ~shift[bit_idx];
                            bit_idx     <= bit_idx + 4'd1;
                        end
                    end else if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        bus.ack_ok  <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.error   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                WAIT_IDLE: begin
                    if (ps2_clk_p1 && ps2_data_p1) begin
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end else if (fall) begin
                        cnt <= '0;
                    end else if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        bus.ack_ok  <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.error   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, a keyboard-side device model
// and a frame reference built from the PS/2 framing rules.
module tb_ps2_host_tx;
    localparam int INH  = 2500;
    localparam int REQ  = 25;
    localparam int TMO  = 1000;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic clr;
    always #20 clk = ~clk;

    ps2_host_tx_if bus();

    logic clk_oe, data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_line, data_line;
    assign clk_line  = ~(clk_oe | dev_clk_low);
    assign data_line = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES(REQ),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus),
        .ps2_clk_in(clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe(clk_oe),
        .ps2_data_oe(data_oe)
    );

    int vec = 0;
    int bad = 0;

    // Line/status monitor
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   rel_cyc = 0;
    int   low_run = 0;
    int   last_low = 0;
    logic ack_at_done = 1'b0;
    logic err_at_done = 1'b0;
    logic [1:0] oe_at_done = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt    <= done_cnt + 1;
            done_cyc    <= cyc;
            ack_at_done <= bus.ack_ok;
            err_at_done <= bus.error;
            oe_at_done  <= {clk_oe, data_oe};
        end
        if (clk_oe) begin
            low_run <= low_run + 1;
        end else begin
            if (low_run != 0) begin
                last_low <= low_run;
                rel_cyc  <= cyc;
            end
            low_run <= 0;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         nfalls;
        bit         ack;
        bit         exp_ack;
        bit         exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame as seen by the device on each rising clock: LSB-first data,
    // odd parity, stop high.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic [9:0] e;
        for (int i = 0; i < 8; i++) e[i] = (b >> i) & 8'd1;
        e[8] = ($countones(b) % 2 == 0);
        e[9] = 1'b1;
        return e;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic request(input logic [7:0] d);
        bit rdy = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (bus.tx_ready) begin rdy = 1; break; end
        end
        if (!rdy) chk("tx_ready_wait", 0, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Keyboard-side model: waits for request-to-send, then clocks bits in.
    task automatic device(input int nfalls, input bit do_ack,
                          output logic [9:0] seen, output bit started);
        started = 0;
        seen    = '0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (clk_line && !data_line) begin started = 1; break; end
        end
        if (!started) return;
        wait_cycles(HALF);
        for (int i = 1; i <= 10 && i <= nfalls; i++) begin
            dev_clk_low = 1'b1;
            wait_cycles(HALF);
            dev_clk_low = 1'b0;
            seen[i-1] = data_line;
            if (i == nfalls) return;
            wait_cycles(HALF);
        end
        if (nfalls < 11) return;
        if (do_ack) dev_data_low = 1'b1;
        wait_cycles(HALF / 2);
        dev_clk_low = 1'b1;
        wait_cycles(HALF);
        dev_clk_low = 1'b0;
        wait_cycles(HALF);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit got = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin got = 1; break; end
        end
        if (!got) chk("done_wait", 0, 1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int d0;
        logic [9:0] seen;
        bit started;
        d0 = done_cnt;
        request(v.data);
        if (v.nfalls > 0) device(v.nfalls, v.ack, seen, started);
        wait_done(d0);
        wait_cycles(5);
        if (v.nfalls > 0) begin
            chk({tag, "_start"}, started, 1);
            chk({tag, "_bits"}, seen, frame_of(v.data));
            chk({tag, "_inhibit_len"}, last_low >= INH, 1);
        end else begin
            chk({tag, "_timeout_lat"}, done_cyc - rel_cyc, TMO);
            chk({tag, "_oe_at_done"}, oe_at_done, 0);
            chk({tag, "_ready_after"}, bus.tx_ready, 1);
        end
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_ack_at_done"}, ack_at_done, v.exp_ack);
        chk({tag, "_err_at_done"}, err_at_done, v.exp_err);
        chk({tag, "_ack_held"}, bus.ack_ok, v.exp_ack);
        chk({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        #(150000 * 40);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [9:0] seen;
        bit started;
        vec_t rv;

        tbl[0] = '{8'hED, 11, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 11, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 11, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h5A,  0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'hF3, 11, 1'b1, 1'b1, 1'b0};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        clr = 1'b1;
        wait_cycles(4);
        clr = 1'b0;
        wait_cycles(1);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_ack_ok", bus.ack_ok, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);

        foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // tx_valid during an active transfer must be ignored
        d0 = done_cnt;
        request(8'hF3);
        wait_cycles(100);
        chk("ign_ready_low", bus.tx_ready, 0);
        bus.tx_data  = 8'hAA;
        bus.tx_valid = 1'b1;
        wait_cycles(1);
        bus.tx_valid = 1'b0;
        device(11, 1'b1, seen, started);
        wait_done(d0);
        chk("ign_bits", seen, frame_of(8'hF3));
        wait_cycles(3000);
        chk("ign_done_once", done_cnt - d0, 1);
        chk("ign_no_requeue", bus.busy, 0);

        // clr after the fifth falling edge aborts without a done pulse
        d0 = done_cnt;
        request(8'h00);
        device(5, 1'b1, seen, started);
        wait_cycles(4);
        chk("clr_pre_data_oe", data_oe, 1);
        clr = 1'b1;
        wait_cycles(1);
        clr = 1'b0;
        chk("clr_clk_oe", clk_oe, 0);
        chk("clr_data_oe", data_oe, 0);
        chk("clr_busy", bus.busy, 0);
        wait_cycles(50);
        chk("clr_no_done", done_cnt - d0, 0);
        run_vec("after_clr", '{8'hFF, 11, 1'b1, 1'b1, 1'b0});

        // Randomized bytes and ACK behaviour
        for (int k = 0; k < 6; k++) begin
            rv.data    = 8'($urandom);
            rv.nfalls  = 11;
            rv.ack     = 1'($urandom_range(0, 1));
            rv.exp_ack = rv.ack;
            rv.exp_err = 1'b0;
            run_vec($sformatf("rnd%0d", k), rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, ...) from the CPU/IO side to the keyboard over the same open-drain ps2_clk/ps2_data lines that ps2_keyboard receives on. It runs on the 25 MHz system clock and performs the full inhibit / request-to-send / device-clocked shift / ACK sequence. It raises busy so the receiver ignores line activity during a transmission.

Parameters:
INHIBIT_CYCLES, 2500, clk cycles ps2_clk is held low before request (100 us at 25 MHz)
REQ_CYCLES, 25, clk cycles data and clk are both held low before clk is released
TIMEOUT_CYCLES, 375000, maximum clk cycles between device clock falling edges (15 ms) before abort

Ports:
clk  input  1  system clock, 25 MHz; sole clock of the block
clr  input  1  synchronous, active-high reset
tx_data  input  8  command byte
tx_valid  input  1  request; accepted when tx_valid & tx_ready
tx_ready  output  1  high only in IDLE
ps2_clk_in  input  1  raw PS/2 clock line (asynchronous)
ps2_data_in  input  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  output  1  1 = drive ps2_clk low, 0 = release
ps2_data_oe  output  1  1 = drive ps2_data low, 0 = release
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at the end of every transfer (ok or failed)
ack_ok  output  1  registered; valid from the done pulse until the next accept
error  output  1  one-cycle pulse, coincident with done, on timeout

Behaviour:
- Clock: only clk. Reset: clr is synchronous, active-high, and sampled on the rising edge of clk.
- Reset state: IDLE. Outputs after reset: ps2_clk_oe=0, ps2_data_oe=0, done=0, error=0, ack_ok=0, busy=0, tx_ready=1.
- clr high mid-transfer: lines are released and state returns to IDLE on that edge. No done pulse.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through 2-FF synchronizers. fall = sync_clk_prev & ~sync_clk.
- IDLE: on tx_valid & tx_ready:
  - latch tx_data into an 11-bit shift value {stop=1, parity=~^tx_data, d7..d0}
  - clear ack_ok, counter=0
  - go INHIBIT
  - tx_valid while not in IDLE is ignored (no queueing).
- INHIBIT: ps2_clk_oe=1. When counter reaches INHIBIT_CYCLES-1, go REQ with counter=0.
- REQ: ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0). After REQ_CYCLES cycles, go SEND with ps2_clk_oe=0, bit index=0, counter=0.
- SEND: data_oe always drives the inverse of the current bit value.
  - Each fall advances the bit index and sets ps2_data_oe = ~bit[index].
  - Falls 1..8 drive d0..d7 (LSB first). Fall 9 drives parity. Fall 10 drives stop (data_oe=0, line released).
  - Fall 11 goes to ACK handling in the same cycle.
- ACK (on fall 11): sample sync_data. ack_ok <= (sync_data==0). Go WAIT_IDLE.
- WAIT_IDLE: wait until sync_clk=1 and sync_data=1 for one cycle. Then pulse done and go IDLE.
- Timeout: in SEND and WAIT_IDLE, counter clears on every fall and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: release both lines, ack_ok=0, pulse done and error, go IDLE.
- Counter: 19 bits, saturating; sized for the largest parameter.
- Simultaneous events: timeout and fall in the same cycle resolve as fall (no error). clr overrides everything.

Test Plan:
- Send 0xED with a device model that clocks at 12 kHz and ACKs -> ps2_clk held low ≥2500 cycles; line bits after start are 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; ack_ok=1; error=0.
- Send 0x00 -> parity bit 1; data bits all 0; ack_ok=1.
- Device clocks all 11 edges but leaves data high at ACK -> done pulses, ack_ok=0, error=0.
- Device never clocks after REQ -> done and error pulse exactly TIMEOUT_CYCLES cycles after clk release; both oe=0; tx_ready=1 next cycle.
- tx_valid pulsed with 0xAA during an active transfer of 0xF3 -> only 0xF3 appears on the line; one done.
- Assert clr after fall 5 -> next cycle ps2_clk_oe=0, ps2_data_oe=0, busy=0, no done; a new 0xFF request then completes with ack_ok=1.
